// File: rtl/tank_gfx_pkg.sv
// Shared types and defaults for the tank graphics fetch stages.
package tank_gfx_pkg;

  // Heading of a tank; the value doubles as the sprite-unit select.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } tank_dir_t;

  localparam int SPRITE_LOG2_DEF = 5;
  localparam int COORD_W_DEF     = 10;
  localparam int BLINK_CNT_W     = 4;

endpackage

// File: rtl/tank_sprite_fetch_if.sv
// Raster-side bus of the tank sprite fetch stage: pixel in, ROM address and
// colour-aligned sidebands out.
interface tank_sprite_fetch_if #(
  parameter int COORD_W     = 10,
  parameter int SPRITE_LOG2 = 5
);
  logic                     draw_valid;
  logic [COORD_W-1:0]       draw_x;
  logic [COORD_W-1:0]       draw_y;
  logic [2*SPRITE_LOG2-1:0] rom_address;
  logic [1:0]               dir_sel;
  logic                     enemy;
  logic                     pix_hit;

  // Raster generator / consumer side
  modport master (
    output draw_valid, draw_x, draw_y,
    input  rom_address, dir_sel, enemy, pix_hit
  );

  // Fetch stage side
  modport slave (
    input  draw_valid, draw_x, draw_y,
    output rom_address, dir_sel, enemy, pix_hit
  );
endinterface

// File: rtl/sideband_delay.sv
// Fixed-depth shift register used to align sideband bits with a ROM read.
// Shared by the tank, bullet and explosion fetch stages.
module sideband_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the sideband word one stage per clock; reset empties the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/tank_sprite_fetch.sv
// Tank sprite fetch: per-frame shadow of one tank's state, box test against
// the raster pixel, sprite ROM address generation and sideband alignment.
// Optional feature macro: TANK_SPAWN_BLINK_EN (spawn-shield blinking).
module tank_sprite_fetch
  import tank_gfx_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int SPRITE_LOG2 = SPRITE_LOG2_DEF,
  parameter int ROM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [COORD_W-1:0]  tank_x,
  input  logic [COORD_W-1:0]  tank_y,
  input  tank_dir_t           tank_dir,
  input  logic                tank_alive,
  input  logic                tank_enemy,
  input  logic                spawn_protect,
  tank_sprite_fetch_if.slave  bus
);

  localparam int ADDR_W = 2 * SPRITE_LOG2;

  logic [COORD_W-1:0] r_sh_x;
  logic [COORD_W-1:0] r_sh_y;
  tank_dir_t          r_sh_dir;
  logic               r_sh_enemy;
  logic               r_sh_alive;

  logic [COORD_W:0]   w_dx;
  logic [COORD_W:0]   w_dy;
  logic               w_inside;
  logic               w_blink_ok;
  logic               w_hit0;

  logic [ADDR_W-1:0]  r_rom_address;
  logic               r_hit1;
  tank_dir_t          r_dir1;
  logic               r_enemy1;
  logic [3:0]         w_side_out;

  // Latch the live tank state once per frame so the sprite never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_x     <= '0;
      r_sh_y     <= '0;
      r_sh_dir   <= DIR_UP;
      r_sh_enemy <= 1'b0;
      r_sh_alive <= 1'b0;
    end else if (frame_start) begin
      r_sh_x     <= tank_x;
      r_sh_y     <= tank_y;
      r_sh_dir   <= tank_dir;
      r_sh_enemy <= tank_enemy;
      r_sh_alive <= tank_alive;
    end
  end

`ifdef TANK_SPAWN_BLINK_EN
  logic [BLINK_CNT_W-1:0] r_blink_cnt;
  logic                   r_sh_protect;

  // Frame counter and shielded flag; top counter bit gives 8 on / 8 off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt  <= '0;
      r_sh_protect <= 1'b0;
    end else if (frame_start) begin
      r_blink_cnt  <= r_blink_cnt + BLINK_CNT_W'(1);
      r_sh_protect <= spawn_protect;
    end
  end

  assign w_blink_ok = !(r_sh_protect & r_blink_cnt[BLINK_CNT_W-1]);
`else
  logic w_unused_spawn_protect;
  assign w_unused_spawn_protect = spawn_protect;
  assign w_blink_ok             = 1'b1;
`endif

  // The extra top bit holds the borrow: a pixel left of / above the sprite
  // (including one past the coordinate wrap) lands outside the box, so a
  // sprite that crosses the screen edge is clipped instead of wrapped.
  assign w_dx     = {1'b0, bus.draw_x} - {1'b0, r_sh_x};
  assign w_dy     = {1'b0, bus.draw_y} - {1'b0, r_sh_y};
  assign w_inside = ((w_dx >> SPRITE_LOG2) == '0) && ((w_dy >> SPRITE_LOG2) == '0);
  assign w_hit0   = bus.draw_valid & r_sh_alive & w_inside & w_blink_ok;

  // ROM address cycle: address is forced to 0 on a miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_address <= '0;
      r_hit1        <= 1'b0;
      r_dir1        <= DIR_UP;
      r_enemy1      <= 1'b0;
    end else begin
      r_rom_address <= w_hit0 ? {w_dy[SPRITE_LOG2-1:0], w_dx[SPRITE_LOG2-1:0]} : '0;
      r_hit1        <= w_hit0;
      r_dir1        <= r_sh_dir;
      r_enemy1      <= r_sh_enemy;
    end
  end

  sideband_delay #(
    .DEPTH (ROM_LATENCY),
    .WIDTH (4)
  ) u_sideband_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data ({r_hit1, r_dir1, r_enemy1}),
    .o_data (w_side_out)
  );

  assign bus.rom_address = r_rom_address;
  assign bus.pix_hit     = w_side_out[3];
  assign bus.dir_sel     = w_side_out[2:1];
  assign bus.enemy       = w_side_out[0];

endmodule
